// File: rtl/pdm_mic_interface.sv
// PDM microphone front end: generates the mic clock, synchronises pad data and
// emits channel-tagged one-bit samples after a warm-up period.
module pdm_mic_interface #(
  parameter int unsigned WARMUP_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [7:0] clock_divisor_i,
  input  logic [1:0] channel_mode_i,
  input  logic       pdm_data_i,
  output logic       pdm_clk_o,
  output logic       pdm_o,
  output logic       valid_o,
  output logic       channel_o,
  output logic       running_o
);

  localparam int unsigned WarmW = $clog2(WARMUP_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_e;

  state_e             state_q, state_d;
  logic [7:0]         div_q, div_d;
  logic [1:0]         mode_q, mode_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WarmW-1:0]   warm_q, warm_d;
  logic               pdm_clk_q, pdm_clk_d;
  logic               edge_q, edge_d;
  logic               pdm_q, pdm_d;
  logic               valid_q, valid_d;
  logic               channel_q, channel_d;
  logic               running_q, running_d;
  logic [SYNC_STAGES-1:0] sync_q;

  logic sync_bit;
  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    warm_d    = warm_q;
    pdm_clk_d = pdm_clk_q;
    edge_d    = 1'b0;
    pdm_d     = pdm_q;
    valid_d   = 1'b0;
    channel_d = channel_q;

    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        warm_d    = '0;
        pdm_clk_d = 1'b0;
        if (enable_i) begin
          state_d = StWarmup;
          div_d   = (clock_divisor_i < 8'd2) ? 8'd2 : clock_divisor_i;
          mode_d  = channel_mode_i;
        end
      end
      StWarmup, StRun: begin
        if (!enable_i) begin
          state_d   = StIdle;
          cnt_d     = '0;
          warm_d    = '0;
          pdm_clk_d = 1'b0;
        end else begin
          if (cnt_q == div_q - 8'd1) begin
            pdm_clk_d = ~pdm_clk_q;
            cnt_d     = '0;
            edge_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
          // edge_q marks the cycle in which pdm_clk_o shows its new level
          if (state_q == StWarmup && edge_q && pdm_clk_q) begin
            if (warm_q == WarmW'(WARMUP_CYCLES - 1)) begin
              state_d = StRun;
            end else begin
              warm_d = warm_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StRun && edge_q) begin
      if (!pdm_clk_q && mode_q != 2'b01) begin
        pdm_d     = sync_bit;
        channel_d = 1'b0;
        valid_d   = 1'b1;
      end else if (pdm_clk_q && mode_q != 2'b00) begin
        pdm_d     = sync_bit;
        channel_d = 1'b1;
        valid_d   = 1'b1;
      end
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      div_q     <= '0;
      mode_q    <= '0;
      cnt_q     <= '0;
      warm_q    <= '0;
      pdm_clk_q <= 1'b0;
      edge_q    <= 1'b0;
      pdm_q     <= 1'b0;
      valid_q   <= 1'b0;
      channel_q <= 1'b0;
      running_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      warm_q    <= warm_d;
      pdm_clk_q <= pdm_clk_d;
      edge_q    <= edge_d;
      pdm_q     <= pdm_d;
      valid_q   <= valid_d;
      channel_q <= channel_d;
      running_q <= running_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pdm_data_i};
    end
  end

  assign pdm_clk_o = pdm_clk_q;
  assign pdm_o     = pdm_q;
  assign valid_o   = valid_q;
  assign channel_o = channel_q;
  assign running_o = running_q;

endmodule

// File: tb/tb_pdm_mic_interface.sv
// Self-checking bench for pdm_mic_interface against a cycle-index timing model.
module tb_pdm_mic_interface;

  localparam int W = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b0;
  logic [7:0] clock_divisor_i = 8'd4;
  logic [1:0] channel_mode_i = 2'b10;
  logic       pdm_data_i = 1'b0;
  logic       pdm_clk_o, pdm_o, valid_o, channel_o, running_o;

  int checks = 0;
  int failures = 0;

  pdm_mic_interface #(
    .WARMUP_CYCLES(W),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .clock_divisor_i(clock_divisor_i),
    .channel_mode_i (channel_mode_i),
    .pdm_data_i     (pdm_data_i),
    .pdm_clk_o      (pdm_clk_o),
    .pdm_o          (pdm_o),
    .valid_o        (valid_o),
    .channel_o      (channel_o),
    .running_o      (running_o)
  );

  always #5 clk_i = ~clk_i;

  // Leave IDLE cleanly, then raise enable so the next cycle is cycle 0.
  task automatic start_run(input logic [7:0] div_in, input logic [1:0] mode);
    @(negedge clk_i);
    enable_i = 1'b0;
    clock_divisor_i = div_in;
    channel_mode_i = mode;
    @(negedge clk_i);
    @(negedge clk_i);
    enable_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    enable_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks += 5;
    if (pdm_clk_o !== 1'b0) begin failures++; $display("FAIL reset_pdm_clk got=%b exp=0", pdm_clk_o); end
    if (pdm_o !== 1'b0) begin failures++; $display("FAIL reset_pdm got=%b exp=0", pdm_o); end
    if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    if (channel_o !== 1'b0) begin failures++; $display("FAIL reset_channel got=%b exp=0", channel_o); end
    if (running_o !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running_o); end
    rst_i = 1'b0;
  endtask

  // Full warm-up + capture timing; pad follows the mic clock phase (1 high, 0 low).
  task automatic test_timing(input logic [7:0] div_in, input logic [1:0] mode, input string name);
    int d, n, k;
    logic exp_clk, exp_run, exp_valid;
    d = (div_in < 2) ? 2 : int'(div_in);
    n = (2 * W + 6) * d + 2;
    start_run(div_in, mode);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      exp_clk = ((c / d) % 2) == 1;
      exp_run = c >= (2 * W - 1) * d + 1;
      k = (c - 1) / d;
      exp_valid = (c >= 1) && ((c - 1) % d == 0) && (k >= 2 * W) &&
                  (((k % 2 == 0) && mode != 2'b01) || ((k % 2 == 1) && mode != 2'b00));
      checks += 3;
      if (pdm_clk_o !== exp_clk) begin
        failures++;
        $display("FAIL %s_pdm_clk cyc=%0d got=%b exp=%b", name, c, pdm_clk_o, exp_clk);
      end
      if (running_o !== exp_run) begin
        failures++;
        $display("FAIL %s_running cyc=%0d got=%b exp=%b", name, c, running_o, exp_run);
      end
      if (valid_o !== exp_valid) begin
        failures++;
        $display("FAIL %s_valid cyc=%0d got=%b exp=%b", name, c, valid_o, exp_valid);
      end
      if (exp_valid) begin
        checks += 2;
        if (channel_o !== logic'(k % 2)) begin
          failures++;
          $display("FAIL %s_channel cyc=%0d got=%b exp=%0d", name, c, channel_o, k % 2);
        end
        if (pdm_o !== logic'(k % 2 == 0)) begin
          failures++;
          $display("FAIL %s_pdm cyc=%0d got=%b exp=%0d", name, c, pdm_o, k % 2 == 0);
        end
      end
      pdm_data_i = exp_clk;
    end
  endtask

  task automatic test_mid_run_reset();
    start_run(8'd4, 2'b10);
    pdm_data_i = 1'b1;
    repeat (41) @(negedge clk_i);
    rst_i = 1'b1;
    enable_i = 1'b0;
    @(negedge clk_i);
    checks += 5;
    if (pdm_clk_o !== 1'b0) begin failures++; $display("FAIL midrst_pdm_clk got=%b exp=0", pdm_clk_o); end
    if (pdm_o !== 1'b0) begin failures++; $display("FAIL midrst_pdm got=%b exp=0", pdm_o); end
    if (valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", valid_o); end
    if (channel_o !== 1'b0) begin failures++; $display("FAIL midrst_channel got=%b exp=0", channel_o); end
    if (running_o !== 1'b0) begin failures++; $display("FAIL midrst_running got=%b exp=0", running_o); end
    rst_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      checks += 2;
      if (pdm_clk_o !== 1'b0) begin failures++; $display("FAIL idle_pdm_clk i=%0d got=%b exp=0", i, pdm_clk_o); end
      if (running_o !== 1'b0) begin failures++; $display("FAIL idle_running i=%0d got=%b exp=0", i, running_o); end
    end
  endtask

  task automatic test_mid_run_changes();
    start_run(8'd4, 2'b10);
    for (int c = 0; c < 61; c++) begin
      @(negedge clk_i);
      checks++;
      if (pdm_clk_o !== logic'((c / 4) % 2 == 1)) begin
        failures++;
        $display("FAIL divchg_pdm_clk cyc=%0d got=%b exp=%0d", c, pdm_clk_o, (c / 4) % 2);
      end
      if (c == 40) clock_divisor_i = 8'd6;
    end
    enable_i = 1'b0;
    @(negedge clk_i);
    checks += 2;
    if (pdm_clk_o !== 1'b0) begin failures++; $display("FAIL disable_pdm_clk got=%b exp=0", pdm_clk_o); end
    if (running_o !== 1'b0) begin failures++; $display("FAIL disable_running got=%b exp=0", running_o); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      checks++;
      if (valid_o !== 1'b0) begin failures++; $display("FAIL disable_valid i=%0d got=%b exp=0", i, valid_o); end
    end
    test_timing(8'd4, 2'b10, "reenable");
  endtask

  // Random bit per mic phase; each channel's sample must match the bit it drove.
  task automatic test_pattern();
    logic bit_hi, bit_lo, last_clk, exp_ch;
    int samples, budget;
    samples = 0;
    budget = 2 * W * 8 + 1000 * 8 + 200;
    last_clk = 1'b0;
    exp_ch = 1'b0;
    bit_hi = 1'($urandom);
    bit_lo = 1'($urandom);
    pdm_data_i = bit_lo;
    start_run(8'd8, 2'b11);
    for (int c = 0; c < budget && samples < 1000; c++) begin
      @(negedge clk_i);
      if (valid_o) begin
        checks += 2;
        if (channel_o !== exp_ch) begin
          failures++;
          $display("FAIL pattern_channel n=%0d got=%b exp=%b", samples, channel_o, exp_ch);
        end
        if (pdm_o !== (exp_ch ? bit_lo : bit_hi)) begin
          failures++;
          $display("FAIL pattern_bit n=%0d got=%b exp=%b", samples, pdm_o, exp_ch ? bit_lo : bit_hi);
        end
        exp_ch = ~exp_ch;
        samples++;
      end
      if (pdm_clk_o !== last_clk) begin
        last_clk = pdm_clk_o;
        if (last_clk) bit_hi = 1'($urandom);
        else bit_lo = 1'($urandom);
      end
      pdm_data_i = last_clk ? bit_hi : bit_lo;
    end
    checks++;
    if (samples != 1000) begin
      failures++;
      $display("FAIL pattern_count got=%0d exp=1000", samples);
    end
  endtask

  task automatic test_random_modes();
    logic [7:0] d;
    logic [1:0] m;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 7));
      m = 2'($urandom_range(0, 3));
      test_timing(d, m, "random");
    end
  endtask

  initial begin
    test_reset();
    test_timing(8'd4, 2'b10, "stereo");
    test_timing(8'd4, 2'b01, "right");
    test_timing(8'd4, 2'b00, "left");
    test_timing(8'd0, 2'b10, "clamp0");
    test_timing(8'd1, 2'b10, "clamp1");
    test_mid_run_reset();
    test_mid_run_changes();
    test_random_modes();
    test_pattern();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
